// File: rtl/sfft_ctrl_pkg.sv
// Shared types and widths for the SFFT stream controller.
// Widths come from the global_variables.sv macros; the fallbacks below cover standalone builds.
`ifndef NFFT
`define NFFT 16
`endif
`ifndef nFFT
`define nFFT 4
`endif
`ifndef SFFT_INPUT_WIDTH
`define SFFT_INPUT_WIDTH 16
`endif
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 16
`endif

package sfft_ctrl_pkg;

    localparam int unsigned NFFT   = `NFFT;
    localparam int unsigned ADDR_W = `nFFT;
    localparam int unsigned IN_W   = `SFFT_INPUT_WIDTH;
    localparam int unsigned OUT_W  = `SFFT_OUTPUT_WIDTH;

    typedef enum logic [1:0] {IDLE, ADV_HIGH, GAP} launch_state_t;
    typedef enum logic       {EMPTY, FULL}         capture_state_t;

    // One complete spectrum as presented on the pipeline's SFFT_Out bus.
    typedef logic [NFFT-1:0][OUT_W-1:0] spectrum_t;

endpackage

// File: rtl/sfft_frame_buffer.sv
// Parallel-load spectrum store with a registered single read port.
// A read in the same cycle as a load returns the pre-load contents.
module sfft_frame_buffer
    import sfft_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  spectrum_t         load_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data
);

    spectrum_t        mem_q, mem_d;
    logic [OUT_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = mem_q[rd_addr];
        if (load) begin
            mem_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q     <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sfft_stream_controller.sv
// Sequences SFFT pipeline launches and snapshots completed spectra for a bin-by-bin reader.
// Optional frame decimation is enabled with `SFFT_DECIMATE_EN.
module sfft_stream_controller
    import sfft_ctrl_pkg::*;
#(
    parameter int unsigned ADV_HIGH_CYCLES = 2,
    parameter int unsigned ADV_MIN_GAP     = NFFT / 2 + 4,
    parameter int unsigned FRAME_HOP       = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [IN_W-1:0]   sample_data,
    output logic              sample_ready,
    output logic [IN_W-1:0]   sfft_sample,
    output logic              sfft_advance,
    input  spectrum_t         sfft_out,
    input  logic              sfft_out_valid,
    output logic              frame_valid,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] bin_addr,
    output logic [OUT_W-1:0]  bin_data,
    output logic [CNT_W-1:0]  frame_seq,
    output logic [CNT_W-1:0]  overrun_cnt
);

    localparam int unsigned LCNT_MAX = (ADV_MIN_GAP > ADV_HIGH_CYCLES) ? ADV_MIN_GAP : ADV_HIGH_CYCLES;
    localparam int unsigned LCNT_W   = $clog2(LCNT_MAX + 1);

    if (ADV_HIGH_CYCLES < 1 || ADV_MIN_GAP < 1 || FRAME_HOP < 1) begin : g_param_check
        $error("sfft_stream_controller: ADV_HIGH_CYCLES, ADV_MIN_GAP and FRAME_HOP must be >= 1");
    end

    launch_state_t   launch_q, launch_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [IN_W-1:0] sample_q, sample_d;
    logic            sample_ready_q, sample_ready_d;
    logic            advance_q, advance_d;
    logic            accept_c;

    capture_state_t  cap_q, cap_d;
    logic [CNT_W-1:0] frame_seq_q, frame_seq_d;
    logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;
    logic            frame_valid_q, frame_valid_d;
    logic            candidate_c;
    logic            capture_c;

    // Launch sequencing: one accepted sample per advance pulse, then a compute gap.
    always_comb begin
        launch_d = launch_q;
        lcnt_d   = lcnt_q;
        sample_d = sample_q;
        accept_c = sample_ready_q && sample_valid;
        unique case (launch_q)
            IDLE: begin
                if (accept_c) begin
                    sample_d = sample_data;
                    launch_d = ADV_HIGH;
                    lcnt_d   = '0;
                end
            end
            ADV_HIGH: begin
                if (lcnt_q == LCNT_W'(ADV_HIGH_CYCLES - 1)) begin
                    launch_d = GAP;
                    lcnt_d   = '0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            GAP: begin
                if (lcnt_q == LCNT_W'(ADV_MIN_GAP - 1)) begin
                    launch_d = IDLE;
                    lcnt_d   = '0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            default: launch_d = IDLE;
        endcase
        sample_ready_d = (launch_d == IDLE);
        advance_d      = (launch_d == ADV_HIGH);
    end

`ifdef SFFT_DECIMATE_EN
    localparam int unsigned HOP_W = $clog2(FRAME_HOP + 1);

    logic [HOP_W-1:0] hop_q, hop_d;

    always_comb begin
        hop_d = hop_q;
        if (sfft_out_valid) begin
            hop_d = (hop_q == HOP_W'(FRAME_HOP - 1)) ? '0 : hop_q + HOP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hop_q <= '0;
        end else begin
            hop_q <= hop_d;
        end
    end

    assign candidate_c = sfft_out_valid && (hop_q == '0);
`else
    assign candidate_c = sfft_out_valid;
`endif

    // Capture: an ack in the same cycle as a new spectrum frees the slot for it.
    always_comb begin
        cap_d         = cap_q;
        frame_seq_d   = frame_seq_q;
        overrun_cnt_d = overrun_cnt_q;
        capture_c     = 1'b0;
        unique case (cap_q)
            EMPTY: begin
                if (candidate_c) begin
                    capture_c = 1'b1;
                    cap_d     = FULL;
                end
            end
            FULL: begin
                if (candidate_c && frame_ack) begin
                    capture_c = 1'b1;
                end else if (candidate_c) begin
                    if (overrun_cnt_q != '1) begin
                        overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
                    end
                end else if (frame_ack) begin
                    cap_d = EMPTY;
                end
            end
            default: cap_d = EMPTY;
        endcase
        if (capture_c) begin
            frame_seq_d = frame_seq_q + CNT_W'(1);
        end
        frame_valid_d = (cap_d == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            launch_q       <= IDLE;
            lcnt_q         <= '0;
            sample_q       <= '0;
            sample_ready_q <= 1'b0;
            advance_q      <= 1'b0;
            cap_q          <= EMPTY;
            frame_seq_q    <= '0;
            overrun_cnt_q  <= '0;
            frame_valid_q  <= 1'b0;
        end else begin
            launch_q       <= launch_d;
            lcnt_q         <= lcnt_d;
            sample_q       <= sample_d;
            sample_ready_q <= sample_ready_d;
            advance_q      <= advance_d;
            cap_q          <= cap_d;
            frame_seq_q    <= frame_seq_d;
            overrun_cnt_q  <= overrun_cnt_d;
            frame_valid_q  <= frame_valid_d;
        end
    end

    sfft_frame_buffer u_frame_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (capture_c),
        .load_data (sfft_out),
        .rd_addr   (bin_addr),
        .rd_data   (bin_data)
    );

    assign sample_ready = sample_ready_q;
    assign sfft_sample  = sample_q;
    assign sfft_advance = advance_q;
    assign frame_valid  = frame_valid_q;
    assign frame_seq    = frame_seq_q;
    assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_sfft_stream_controller.sv
// Directed bench for sfft_stream_controller: launch timing, capture/overrun, counter limits, decimation.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_sfft_stream_controller;
    import sfft_ctrl_pkg::*;

    localparam int unsigned CNT_W = 16;
`ifdef SFFT_DECIMATE_EN
    localparam int HOP = 4;
`else
    localparam int HOP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [IN_W-1:0]   sample_data;
    logic              sample_ready;
    logic [IN_W-1:0]   sfft_sample;
    logic              sfft_advance;
    spectrum_t         sfft_out;
    logic              sfft_out_valid;
    logic              frame_valid;
    logic              frame_ack;
    logic [ADDR_W-1:0] bin_addr;
    logic [OUT_W-1:0]  bin_data;
    logic [CNT_W-1:0]  frame_seq;
    logic [CNT_W-1:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    sfft_stream_controller #(
        .ADV_HIGH_CYCLES (2),
        .ADV_MIN_GAP     (NFFT / 2 + 4),
        .FRAME_HOP       (4),
        .CNT_W           (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_ready   (sample_ready),
        .sfft_sample    (sfft_sample),
        .sfft_advance   (sfft_advance),
        .sfft_out       (sfft_out),
        .sfft_out_valid (sfft_out_valid),
        .frame_valid    (frame_valid),
        .frame_ack      (frame_ack),
        .bin_addr       (bin_addr),
        .bin_data       (bin_data),
        .frame_seq      (frame_seq),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bins(input int mult, input int off);
        for (int k = 0; k < int'(NFFT); k++) begin
            sfft_out[k] = OUT_W'(k * mult + off);
        end
    endtask

    task automatic rd(input int addr, input int exp, input string tag);
        bin_addr = ADDR_W'(addr);
        @(negedge clk);
        chk(tag, 32'(bin_data), 32'(exp));
    endtask

    task automatic pulse_out(input logic ack);
        sfft_out_valid = 1'b1;
        frame_ack      = ack;
        @(negedge clk);
        sfft_out_valid = 1'b0;
        frame_ack      = 1'b0;
    endtask

    initial begin
        int            rises;
        int            rise_t [1:2];
        int            hi_cnt [1:2];
        int            stab_err;
        logic          adv_prev;
        logic [IN_W-1:0] exp_s [1:2];
        int            last_p;

        reset          = 1'b0;
        sample_valid   = 1'b1;
        sample_data    = IN_W'(16'h0100);
        sfft_out_valid = 1'b0;
        frame_ack      = 1'b0;
        bin_addr       = '0;
        sfft_out       = '0;

        // Reset state while a sample is being offered
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(sample_ready), 32'd0);
        chk("rst_advance", 32'(sfft_advance), 32'd0);
        chk("rst_sample", 32'(sfft_sample), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_frame_seq", 32'(frame_seq), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_bin_data", 32'(bin_data), 32'd0);

        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(sample_ready), 32'd1);
        chk("post_rst_advance", 32'(sfft_advance), 32'd0);

        // Back-to-back launches: measure pulse widths and spacing
        exp_s[1] = IN_W'(16'h0100);
        exp_s[2] = IN_W'(16'hFF00);
        rises    = 0;
        rise_t   = '{0, 0};
        hi_cnt   = '{0, 0};
        stab_err = 0;
        adv_prev = 1'b0;
        for (int i = 2; i <= 45; i++) begin
            @(negedge clk);
            if (sfft_advance && !adv_prev) begin
                rises++;
                if (rises <= 2) rise_t[rises] = i;
                if (rises == 1) sample_data = IN_W'(16'hFF00);
                if (rises == 2) sample_valid = 1'b0;
            end
            if (sfft_advance && rises >= 1 && rises <= 2) begin
                hi_cnt[rises]++;
                if (sfft_sample !== exp_s[rises] || sample_ready !== 1'b0) stab_err++;
            end
            adv_prev = sfft_advance;
        end
        chk("first_rise_cycle", 32'(rise_t[1]), 32'd2);
        chk("rise_to_rise", 32'(rise_t[2] - rise_t[1]), 32'(1 + 2 + NFFT / 2 + 4));
        chk("adv_width_1", 32'(hi_cnt[1]), 32'd2);
        chk("adv_width_2", 32'(hi_cnt[2]), 32'd2);
        chk("adv_pulse_count", 32'(rises), 32'd2);
        chk("sample_stable", 32'(stab_err), 32'd0);
        chk("sample_held", 32'(sfft_sample), 32'h0000FF00);

        // First capture; a read in the capture cycle returns the old contents
        set_bins(3, 0);
        bin_addr = ADDR_W'(5);
        pulse_out(1'b0);
        chk("cap_read_old", 32'(bin_data), 32'd0);
        chk("cap_frame_valid", 32'(frame_valid), 32'd1);
        chk("cap_frame_seq", 32'(frame_seq), 32'd1);
        chk("cap_overrun", 32'(overrun_cnt), 32'd0);
        @(negedge clk);
        chk("cap_bin5", 32'(bin_data), 32'd15);

        // Overrun: buffer untouched
        set_bins(7, 0);
        pulse_out(1'b0);
        chk("ovr_count", 32'(overrun_cnt), 32'd1);
        chk("ovr_frame_valid", 32'(frame_valid), 32'd1);
        chk("ovr_frame_seq", 32'(frame_seq), 32'd1);
        rd(5, 15, "ovr_bin5");
        rd(15, 45, "ovr_bin15");

        // Ack together with a new spectrum: captured, stays full, no overrun
        set_bins(5, 0);
        pulse_out(1'b1);
        chk("ackcap_frame_valid", 32'(frame_valid), 32'd1);
        chk("ackcap_frame_seq", 32'(frame_seq), 32'd2);
        chk("ackcap_overrun", 32'(overrun_cnt), 32'd1);
        rd(15, 75, "ackcap_bin15");
        rd(5, 25, "ackcap_bin5");

        // Plain ack empties; ack while empty is ignored
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_empty", 32'(frame_valid), 32'd0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_idle_fv", 32'(frame_valid), 32'd0);
        chk("ack_idle_seq", 32'(frame_seq), 32'd2);
        chk("ack_idle_ovr", 32'(overrun_cnt), 32'd1);

        // Counter limits: preload near the top, then wrap frame_seq and saturate overrun_cnt
        force dut.overrun_cnt_q = CNT_W'(16'hFFFE);
        force dut.frame_seq_q   = CNT_W'(16'hFFFF);
        #1;
        release dut.overrun_cnt_q;
        release dut.frame_seq_q;
        @(negedge clk);
        set_bins(11, 0);
        pulse_out(1'b0);
        chk("seq_wrap", 32'(frame_seq), 32'd0);
        chk("wrap_frame_valid", 32'(frame_valid), 32'd1);
        set_bins(13, 0);
        sfft_out_valid = 1'b1;
        @(negedge clk);
        chk("sat_first_drop", 32'(overrun_cnt), 32'h0000FFFF);
        repeat (2) @(negedge clk);
        sfft_out_valid = 1'b0;
        chk("sat_hold", 32'(overrun_cnt), 32'h0000FFFF);
        chk("sat_seq", 32'(frame_seq), 32'd0);
        rd(5, 55, "sat_bin5");
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;

        // Reset in the middle of an advance pulse drops it at once
        sample_valid = 1'b1;
        sample_data  = IN_W'(16'h1234);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("mid_adv_high", 32'(sfft_advance), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_advance", 32'(sfft_advance), 32'd0);
        chk("mid_rst_sample", 32'(sfft_sample), 32'd0);
        chk("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("mid_rst_ready", 32'(sample_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(5, 0, "bin_after_reset");

        // Eight acked spectra; with decimation only every HOP-th is captured
        for (int p = 0; p < 8; p++) begin
            set_bins(1, p * 256);
            pulse_out(1'b0);
            chk($sformatf("dec_fv_p%0d", p), 32'(frame_valid), 32'((p % HOP) == 0));
            frame_ack = 1'b1;
            @(negedge clk);
            frame_ack = 1'b0;
        end
        last_p = (7 / HOP) * HOP;
        chk("dec_frame_seq", 32'(frame_seq), 32'(8 / HOP));
        chk("dec_overrun", 32'(overrun_cnt), 32'd0);
        rd(3, 3 + last_p * 256, "dec_bin3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
